io_input_fifo: RTL and testbench

- Receive-side byte buffer directly downstream of the UART receiver (I_O_INPUT_CONTROLLER).
- Captures each byte the receiver announces on io_input_trigger/io_input_value into a circular FIFO.
- The RISC-V core's I/O interface drains the FIFO through a one-cycle-latency read handshake.
- Decouples bursty serial reception from CPU polling and flags bytes lost to overflow.

---
 rtl/io_input_fifo.sv | 128 ++++++++++++
 tb/tb_io_input_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_fifo.sv
// io_input_fifo: receive-side byte FIFO between the UART receiver and the
// CPU I/O interface. A byte is captured on each rising edge of the
// receiver's trigger strobe. The CPU pops with a one-cycle-latency read
// handshake. Bytes arriving while the buffer is full are dropped, and the
// drop is recorded in a sticky overflow flag.
module io_input_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          io_input_trigger,
    input  logic [7:0]    io_input_value,
    input  logic          read_request,
    output logic          read_valid,
    output logic [7:0]    read_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    input  logic          overflow_clear
);

    // Storage and state registers
    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0] r_count;
    logic        r_empty;
    logic        r_full;
    logic        r_read_valid;
    logic [7:0]  r_read_data;
    logic        r_overflow;
    logic        r_trig_q;

    // Combinational control
    logic        w_push;
    logic        w_pop;
    logic        w_push_acc;
    logic        w_drop;
    logic [AW:0] w_count_nxt;

    // Event decode: rising trigger edge is a push; pop uses registered empty.
    always_comb begin
        w_push     = io_input_trigger & ~r_trig_q;
        w_pop      = read_request & ~r_empty;
        // A full FIFO still accepts a byte when a slot frees in the same cycle.
        w_push_acc = w_push & (~r_full | w_pop);
        w_drop     = w_push & r_full & ~w_pop;
    end

    // Next occupancy from the accepted push and the pop of this cycle.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            2'b11:   w_count_nxt = r_count;
            2'b00:   w_count_nxt = r_count;
            default: w_count_nxt = r_count;
        endcase
    end

    // Byte storage; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= io_input_value;
        end
    end

    // Pointers, occupancy flags and the trigger history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            // Start high so a trigger already asserted at release is ignored.
            r_trig_q <= 1'b1;
        end else begin
            r_trig_q <= io_input_trigger;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == (AW+1)'(0));
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
        end
    end

    // Read port: one-cycle pulse with the popped byte, data held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read_valid <= 1'b0;
            r_read_data  <= 8'h00;
        end else begin
            r_read_valid <= w_pop;
            if (w_pop) begin
                r_read_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Sticky overflow: a new drop takes priority over a clear request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clear) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign read_valid = r_read_valid;
    assign read_data  = r_read_data;
    assign count      = r_count;
    assign empty      = r_empty;
    assign full       = r_full;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_io_input_fifo.sv
// Testbench for io_input_fifo: directed scenarios plus a randomized run
// compared cycle by cycle against a queue-based reference model.
module tb_io_input_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          io_input_trigger = 1'b0;
    logic [7:0]    io_input_value = 8'h00;
    logic          read_request = 1'b0;
    logic          read_valid;
    logic [7:0]    read_data;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          overflow_clear = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_trig_q  = 1'b1;
    logic       m_ovf     = 1'b0;
    logic       m_valid   = 1'b0;
    logic [7:0] m_data    = 8'h00;

    io_input_fifo #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .io_input_trigger (io_input_trigger),
        .io_input_value   (io_input_value),
        .read_request     (read_request),
        .read_valid       (read_valid),
        .read_data        (read_data),
        .count            (count),
        .empty            (empty),
        .full             (full),
        .overflow         (overflow),
        .overflow_clear   (overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_trig_q = 1'b1;
        m_ovf    = 1'b0;
        m_valid  = 1'b0;
        m_data   = 8'h00;
    endtask

    // Drive one cycle of inputs, clock it, and advance the reference model.
    task automatic cyc(input logic trig, input logic [7:0] val,
                       input logic rr, input logic oc);
        bit push, pop, acc;
        io_input_trigger = trig;
        io_input_value   = val;
        read_request     = rr;
        overflow_clear   = oc;
        @(posedge clk);
        #1;
        push = trig && !m_trig_q;
        pop  = rr && (m_q.size() > 0);
        acc  = push && ((m_q.size() < DEPTH) || pop);
        m_valid = pop;
        if (pop) m_data = m_q.pop_front();
        if (acc) m_q.push_back(val);
        if (push && !acc) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        m_trig_q = trig;
    endtask

    task automatic push_byte(input logic [7:0] v);
        cyc(1'b1, v, 1'b0, 1'b0);
        cyc(1'b0, v, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b required 0/1/0", count, empty, full);
        end
        n_checks++;
        if (overflow !== 1'b0 || read_valid !== 1'b0 || read_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_read: ovf=%b valid=%b data=%h required 0/0/00", overflow, read_valid, read_data);
        end
        reset_n = 1'b1;
        model_reset();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_single_byte();
        repeat (3) cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd1) begin
            n_errors++;
            $display("FAIL single_count: got %0d required 1", count);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (read_valid !== 1'b1 || read_data !== 8'hAA || count !== 5'd0 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL single_pop: valid=%b data=%h count=%0d empty=%b required 1/aa/0/1",
                     read_valid, read_data, count, empty);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (read_valid !== 1'b0 || read_data !== 8'hAA) begin
            n_errors++;
            $display("FAIL single_after: valid=%b data=%h required 0/aa", read_valid, read_data);
        end
        // Read while empty is ignored.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (read_valid !== 1'b0 || read_data !== 8'hAA || count !== 5'd0) begin
            n_errors++;
            $display("FAIL empty_read: valid=%b data=%h count=%0d required 0/aa/0", read_valid, read_data, count);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        n_checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL fill: full=%b count=%0d ovf=%b required 1/16/0", full, count, overflow);
        end
        push_byte(8'h10);
        n_checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            n_errors++;
            $display("FAIL overflow_set: ovf=%b count=%0d required 1/16", overflow, count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (read_valid !== 1'b1 || read_data !== 8'(i)) begin
                n_errors++;
                $display("FAIL drain[%0d]: valid=%b data=%h required 1/%h", i, read_valid, read_data, 8'(i));
            end
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (empty !== 1'b1 || overflow !== 1'b1 || read_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drained: empty=%b ovf=%b valid=%b required 1/1/0", empty, overflow, read_valid);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_clear: got %b required 0", overflow);
        end
        overflow_clear = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            push_byte(8'hE0 + 8'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) push_byte(8'h20 + 8'(i));
        n_checks++;
        if (count !== 5'd10) begin
            n_errors++;
            $display("FAIL wrap_count: got %0d required 10", count);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (read_valid !== 1'b1 || read_data !== 8'h20 + 8'(i)) begin
                n_errors++;
                $display("FAIL wrap[%0d]: valid=%b data=%h required 1/%h", i, read_valid, read_data, 8'h20 + 8'(i));
            end
        end
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_end: count=%0d empty=%b required 0/1", count, empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) push_byte(8'h30 + 8'(i));
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        n_checks++;
        if (read_valid !== 1'b1 || read_data !== 8'h30 || count !== 5'd16 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL full_push_pop: valid=%b data=%h count=%0d ovf=%b required 1/30/16/0",
                     read_valid, read_data, count, overflow);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (read_data !== ((i == DEPTH) ? 8'h55 : 8'h30 + 8'(i))) begin
                n_errors++;
                $display("FAIL full_drain[%0d]: data=%h required %h", i, read_data,
                         ((i == DEPTH) ? 8'h55 : 8'h30 + 8'(i)));
            end
        end
        cyc(1'b1, 8'h66, 1'b1, 1'b0);
        n_checks++;
        if (read_valid !== 1'b0 || count !== 5'd1) begin
            n_errors++;
            $display("FAIL empty_push_read: valid=%b count=%0d required 0/1", read_valid, count);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (read_valid !== 1'b1 || read_data !== 8'h66) begin
            n_errors++;
            $display("FAIL empty_push_next: valid=%b data=%h required 1/66", read_valid, read_data);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i));
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        read_request = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 5'd0 || empty !== 1'b1 || read_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: count=%0d empty=%b valid=%b required 0/1/0", count, empty, read_valid);
        end
        io_input_trigger = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        // Trigger already high at release must not be captured.
        repeat (3) cyc(1'b1, 8'h99, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd0 || read_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL release_trigger: count=%0d valid=%b required 0/0", count, read_valid);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        push_byte(8'h77);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (read_valid !== 1'b1 || read_data !== 8'h77) begin
            n_errors++;
            $display("FAIL post_reset_pop: valid=%b data=%h required 1/77", read_valid, read_data);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 19) == 0));
            n_checks++;
            if (read_valid !== m_valid || count !== (AW+1)'(m_q.size()) ||
                empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH) ||
                overflow !== m_ovf || read_data !== m_data) begin
                n_errors++;
                $display("FAIL random[%0d]: valid=%b data=%h count=%0d empty=%b full=%b ovf=%b required %b/%h/%0d/%b/%b/%b",
                         n, read_valid, read_data, count, empty, full, overflow,
                         m_valid, m_data, m_q.size(), (m_q.size() == 0), (m_q.size() == DEPTH), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
